store_monitor: RTL

STORE_MONITOR -- requirements
Module: store_monitor

---
 rtl/store_monitor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/store_monitor.sv
`default_nettype none
// ============================================================================
// Module   : store_monitor
// Purpose  : Observes processor data-memory stores. Every store is queued as
//            an {address, data} record in a FIFO for a downstream consumer,
//            and is also counted. The first store to PASS_ADDR ends the
//            program: done is raised, and pass shows whether that store's
//            data equalled PASS_DATA.
// Ports    : clk          - single clock, rising edge
//            reset        - synchronous, active-high
//            memwrite     - store strobe, one store per high cycle
//            dataadr      - store address
//            writedata    - store data
//            out_valid    - FIFO head record available
//            out_ready    - consumer accepts head record
//            out_addr     - head record address (0 while out_valid=0)
//            out_data     - head record data    (0 while out_valid=0)
//            overflow     - sticky, at least one store was dropped
//            store_count  - saturating count of stores seen
//            done         - sticky, a store to PASS_ADDR was seen
//            pass         - first PASS_ADDR store carried PASS_DATA
// Revision : 1.0 - initial release
// ============================================================================
module store_monitor #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] PASS_ADDR = 32'd84,
  parameter logic [31:0] PASS_DATA = 32'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        overflow,
  output logic [15:0] store_count,
  output logic        done,
  output logic        pass
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [15:0]   r_store_count;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_pass;
  logic          w_pass_nxt;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [63:0]   w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);
  assign w_pop   = !w_empty && out_ready;
  // A full FIFO still accepts a store when the head leaves on the same edge.
  assign w_push  = memwrite && (!w_full || w_pop);

  // FIFO control, counters and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_store_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (memwrite && !w_push) r_overflow <= 1'b1;
      if (memwrite && (r_store_count != 16'hFFFF))
        r_store_count <= r_store_count + 16'd1;
    end
  end

  // Record storage carries no reset; the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wptr] <= {dataadr, writedata};
  end

  // Completion FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  // Completion FSM next state: only the first PASS_ADDR store decides pass.
  always_comb begin
    w_state_nxt = r_state;
    w_pass_nxt  = r_pass;
    case (r_state)
      ST_IDLE: begin
        if (memwrite && (dataadr == PASS_ADDR)) begin
          w_state_nxt = ST_DONE;
          w_pass_nxt  = (writedata == PASS_DATA);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pass_nxt  = 1'b0;
      end
    endcase
  end

  assign w_head      = r_mem[r_rptr];
  assign out_valid   = !w_empty && !reset;
  assign out_addr    = out_valid ? w_head[63:32] : 32'd0;
  assign out_data    = out_valid ? w_head[31:0]  : 32'd0;
  assign overflow    = r_overflow;
  assign store_count = r_store_count;
  assign done        = (r_state == ST_DONE);
  assign pass        = done && r_pass;

endmodule
`default_nettype wire
